dmem_lsu_ctrl: RTL

// Load/store controller in front of the byte-laned data memory (dmem). Arbitrates two requesters (port 0 = CPU,

---
 rtl/dmem_lsu_ctrl_pkg.sv | 61 ++++++
 rtl/dmem_lsu_ctrl_rr_arb2.sv | 33 +++
 rtl/dmem_lsu_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared types and constants for the dmem load/store controller.
// Pure definitions, no timing.
// No flow control of its own; users apply these in the controller datapath.
package dmem_lsu_ctrl_pkg;

  // Access size codes as presented by the requesters
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Lane masks used by aligned and byte beats
  localparam logic [3:0] LANE_NONE = 4'h0;
  localparam logic [3:0] LANE_B0   = 4'h1;
  localparam logic [3:0] LANE_H0   = 4'h3;
  localparam logic [3:0] LANE_H1   = 4'hC;
  localparam logic [3:0] LANE_W    = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } lsu_state_e;

  // One requester's transaction, latched on grant
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Number of bytes touched minus one (illegal size is rejected elsewhere)
  function automatic logic [1:0] size_bytes_m1(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes_m1 = 2'd0;
      SZ_HALF: size_bytes_m1 = 2'd1;
      default: size_bytes_m1 = 2'd3;
    endcase
  endfunction

  // Lane mask of a single naturally aligned beat
  function automatic logic [3:0] aligned_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: aligned_mask = LANE_B0 << off;
      SZ_HALF: aligned_mask = off[1] ? LANE_H1 : LANE_H0;
      default: aligned_mask = LANE_W;
    endcase
  endfunction

  // Sign or zero extension of right-justified load data
  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] size,
                                              input logic uns);
    case (size)
      SZ_BYTE: extend_load = {{24{d[7] & ~uns}}, d[7:0]};
      SZ_HALF: extend_load = {{16{d[15] & ~uns}}, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on contention the port not granted last wins.
// Combinational grant, pointer updates on the accepting edge.
// Grant is only advisory until accept_i; no state changes without accept_i.
module dmem_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;  // 0: port 0 preferred on contention

  // Preferred port on contention, otherwise the lone requester
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
    else                gnt_o = req_i;
  end

  // After granting port 0 prefer port 1, and vice versa
  always_comb begin
    prio_d = prio_q;
    if (accept_i && (|gnt_o)) prio_d = gnt_o[0];
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller: arbitrates CPU/DMA ports and splits misaligned accesses into byte beats.
// Request seen in cycle N -> beats N+1..N+k -> rsp_valid in N+k+1 (errors: rsp in N+1, no beats).
// Requesters hold req until rsp_valid; the responding port is masked from arbitration that cycle.
module dmem_lsu_ctrl
  import dmem_lsu_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic [3:0]  mem_re,
  output logic        mem_sign,
  output logic        mem_new,
  input  logic [31:0] mem_rdata
);

  // First byte address past the end of dmem
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  lsu_state_e  state_q, state_d;

  // Latched transaction and beat sequencing
  lsu_req_t    req_q;
  logic        port_q;
  logic        split_q;
  logic [1:0]  last_beat_q;
  logic [1:0]  beat_q;
  logic [31:0] asm_q, asm_d;

  // Registered response / handshake outputs
  logic        gnt0_q, gnt1_q;
  logic        rsp_valid_q, rsp_port_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        mem_new_q;

  // Arbitration and classification of the candidate request
  logic [1:0]  arb_req, arb_gnt;
  logic        accept;
  logic        sel_port;
  lsu_req_t    sel_req;
  logic        sel_split;
  logic [1:0]  sel_last_beat;
  logic [32:0] sel_end;
  logic        sel_err;

  // Current beat
  logic        is_idle, is_acc, last_beat;
  logic [31:0] beat_addr;
  logic [3:0]  beat_mask;
  logic [31:0] beat_dat;

  assign is_idle   = (state_q == ST_IDLE);
  assign is_acc    = (state_q == ST_ACC);
  assign last_beat = (beat_q == last_beat_q);

  // A port is being answered this cycle; it would otherwise be re-granted on its stale req
  assign arb_req[0] = p0_req & ~(rsp_valid_q & ~rsp_port_q);
  assign arb_req[1] = p1_req & ~(rsp_valid_q &  rsp_port_q);
  assign accept     = is_idle & (|arb_req);

  dmem_rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (arb_req),
    .accept_i (accept),
    .gnt_o    (arb_gnt)
  );

  // Select the granted port and work out beat count and range errors before any beat
  always_comb begin
    sel_port = arb_gnt[1];
    if (sel_port) begin
      sel_req = '{we: p1_we, size: p1_size, uns: p1_unsigned, addr: p1_addr, wdata: p1_wdata};
    end else begin
      sel_req = '{we: p0_we, size: p0_size, uns: p0_unsigned, addr: p0_addr, wdata: p0_wdata};
    end
    sel_split     = 1'b0;
    sel_last_beat = 2'd0;
    if (sel_req.size == SZ_HALF && sel_req.addr[0]) begin
      sel_split     = 1'b1;
      sel_last_beat = 2'd1;
    end else if (sel_req.size == SZ_WORD && sel_req.addr[1:0] != 2'b00) begin
      sel_split     = 1'b1;
      sel_last_beat = 2'd3;
    end
    // Last byte touched; covers the word+1 of a crossing access
    sel_end = {1'b0, sel_req.addr} + {31'd0, size_bytes_m1(sel_req.size)};
    sel_err = (sel_req.size == SZ_ILL) || (sel_end >= BYTE_LIMIT);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: illegal requests never leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !sel_err) state_d = ST_ACC;
      ST_ACC:  if (last_beat)          state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: drive the dmem beat only while in ACC
  always_comb begin
    beat_addr = req_q.addr + {30'd0, beat_q};
    if (split_q) begin
      beat_mask = LANE_B0 << beat_addr[1:0];
      beat_dat  = {24'd0, req_q.wdata[{beat_q, 3'b000} +: 8]};
    end else begin
      beat_mask = aligned_mask(req_q.size, req_q.addr[1:0]);
      beat_dat  = req_q.wdata;
    end
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = LANE_NONE;
    mem_re    = LANE_NONE;
    if (is_acc) begin
      mem_addr = {2'b00, beat_addr[31:2]};
      if (req_q.we) begin
        mem_we    = beat_mask;
        mem_wdata = beat_dat;
      end else begin
        mem_re = beat_mask;
      end
    end
  end

  // Load assembly: byte beats fill ascending bytes, a single beat takes the whole word
  always_comb begin
    asm_d = asm_q;
    if (is_acc && !req_q.we) begin
      if (split_q) asm_d[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
      else         asm_d = mem_rdata;
    end
  end

  // Latch the accepted request and step through its beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      port_q      <= 1'b0;
      split_q     <= 1'b0;
      last_beat_q <= 2'd0;
      beat_q      <= 2'd0;
      asm_q       <= '0;
    end else if (accept) begin
      req_q       <= sel_req;
      port_q      <= sel_port;
      split_q     <= sel_split;
      last_beat_q <= sel_last_beat;
      beat_q      <= 2'd0;
      asm_q       <= '0;
    end else if (is_acc) begin
      beat_q      <= beat_q + 2'd1;
      asm_q       <= asm_d;
    end
  end

  // Grant pulse, response pulse with extended data, and the dmem retrigger toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_new_q   <= 1'b0;
    end else begin
      gnt0_q      <= accept & arb_gnt[0];
      gnt1_q      <= accept & arb_gnt[1];
      rsp_valid_q <= (accept && sel_err) || (is_acc && last_beat);
      rsp_port_q  <= accept ? sel_port : port_q;
      rsp_err_q   <= accept && sel_err;
      rsp_rdata_q <= (is_acc && last_beat && !req_q.we) ?
                     extend_load(asm_d, req_q.size, req_q.uns) : '0;
      mem_new_q   <= mem_new_q ^ (state_d == ST_ACC);
    end
  end

  assign p0_gnt       = gnt0_q;
  assign p1_gnt       = gnt1_q;
  assign p0_rsp_valid = rsp_valid_q & ~rsp_port_q;
  assign p1_rsp_valid = rsp_valid_q &  rsp_port_q;
  assign p0_rdata     = p0_rsp_valid ? rsp_rdata_q : '0;
  assign p1_rdata     = p1_rsp_valid ? rsp_rdata_q : '0;
  assign p0_err       = p0_rsp_valid & rsp_err_q;
  assign p1_err       = p1_rsp_valid & rsp_err_q;
  assign mem_sign     = 1'b1;
  assign mem_new      = mem_new_q;

endmodule
